// File: rtl/ifft_conj_stage_16b_pkg.sv
// Shared constants and the stage-1 payload type for the IFFT conjugate/scale stage.
package ifft_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int FRAME_LEN  = 64;
    localparam int SHIFT      = 6;
    localparam int CNT_W      = $clog2(FRAME_LEN);

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = 16'h8000;
    localparam logic [DATA_WIDTH-1:0] MAX_POS = 16'h7FFF;

    // Half an LSB of the scaled result, added before the arithmetic shift.
    localparam logic [DATA_WIDTH:0] ROUND_BIAS = (DATA_WIDTH+1)'(1 << (SHIFT-1));

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
        logic                  last;
        logic                  sat;
        logic                  first;
        logic                  scale;
    } s1_t;
endpackage

// File: rtl/ifft_conj_stage_16b_sat_negate.sv
// Saturating two's-complement negation built from an inverter and a Kogge-Stone adder.
module notgate #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_y
);
    assign o_y = ~i_a;
endmodule

module ksa_top_16b (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_c0,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [15:0] r_g [5];
    logic [15:0] r_p [4];
    logic [15:0] w_c;

    // Prefix tree over shifted vectors; the low bits below each span keep their value.
    always_comb begin
        r_g[0]    = i_a & i_b;
        r_p[0]    = i_a ^ i_b;
        r_g[0][0] = r_g[0][0] | (r_p[0][0] & i_c0);
        r_g[1] = r_g[0] | (r_p[0] & (r_g[0] << 1));
        r_p[1] = r_p[0] & ((r_p[0] << 1) | 16'h0001);
        r_g[2] = r_g[1] | (r_p[1] & (r_g[1] << 2));
        r_p[2] = r_p[1] & ((r_p[1] << 2) | 16'h0003);
        r_g[3] = r_g[2] | (r_p[2] & (r_g[2] << 4));
        r_p[3] = r_p[2] & ((r_p[2] << 4) | 16'h000F);
        r_g[4] = r_g[3] | (r_p[3] & (r_g[3] << 8));
    end

    assign w_c    = {r_g[4][14:0], i_c0};
    assign o_sum  = r_p[0] ^ w_c;
    assign o_cout = r_g[4][15];
endmodule

module sat_negate_16b
    import ifft_pkg::*;
(
    input  logic [15:0] i_a,
    output logic [15:0] o_r,
    output logic        o_sat
);
    logic [15:0] w_inv;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_unused_cout;

    notgate #(.W(16)) u_not (
        .i_a (i_a),
        .o_y (w_inv)
    );

    ksa_top_16b u_add (
        .i_a    (w_inv),
        .i_b    (16'h0000),
        .i_c0   (1'b1),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Only -32768 turns a non-negative ~A into a negative sum: signed overflow.
    assign o_sat         = ~w_inv[15] & w_sum[15];
    assign o_r           = o_sat ? MAX_POS : w_sum;
    assign w_unused_cout = w_cout;
endmodule

// File: rtl/ifft_conj_stage_16b.sv
// Two-stage elastic conjugate/scale stage, framed in FRAME_LEN-sample blocks.
module ifft_conj_stage_16b
    import ifft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_mode,
    input  logic                  i_scale_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_re,
    input  logic [DATA_WIDTH-1:0] i_im,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_re,
    output logic [DATA_WIDTH-1:0] o_im,
    output logic                  o_last,
    output logic                  o_sat
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN-1);

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mode;
    logic                  r_scale;
    logic                  r_s1_valid;
    s1_t                   r_s1;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_re;
    logic [DATA_WIDTH-1:0] r_s2_im;
    logic                  r_s2_last;
    logic                  r_s2_sat;
    logic                  r_s2_first;
    logic                  r_osat;

    logic                  w_s1_adv;
    logic                  w_ready;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_first;
    logic                  w_mode;
    logic                  w_scale;
    logic [DATA_WIDTH-1:0] w_neg_im;
    logic                  w_neg_sat;
    logic [DATA_WIDTH-1:0] w_s1_im;
    logic                  w_s1_sat;
    logic [DATA_WIDTH:0]   w_re_sum;
    logic [DATA_WIDTH:0]   w_im_sum;
    logic [DATA_WIDTH-1:0] w_re_rnd;
    logic [DATA_WIDTH-1:0] w_im_rnd;
    logic [DATA_WIDTH-1:0] w_s2_re;
    logic [DATA_WIDTH-1:0] w_s2_im;
    logic                  w_unused_lsb;

    assign w_s1_adv   = !r_s2_valid | i_ready;
    assign w_ready    = !r_s1_valid | w_s1_adv;
    assign w_in_xfer  = i_valid & w_ready;
    assign w_out_xfer = r_s2_valid & i_ready;

    // Sample 0 uses the live controls so the whole frame sees the same setting.
    assign w_first = (r_cnt == '0);
    assign w_mode  = w_first ? i_mode     : r_mode;
    assign w_scale = w_first ? i_scale_en : r_scale;

    sat_negate_16b u_neg (
        .i_a   (i_im),
        .o_r   (w_neg_im),
        .o_sat (w_neg_sat)
    );

    assign w_s1_im  = (w_mode == MODE_INV) ? w_neg_im : i_im;
    assign w_s1_sat = (w_mode == MODE_INV) & w_neg_sat;

    // 17-bit sums cannot overflow; keep the sign-extended upper bits after the shift.
    assign w_re_sum = {r_s1.re[DATA_WIDTH-1], r_s1.re} + ROUND_BIAS;
    assign w_im_sum = {r_s1.im[DATA_WIDTH-1], r_s1.im} + ROUND_BIAS;
    assign w_re_rnd = {{(SHIFT-1){w_re_sum[DATA_WIDTH]}}, w_re_sum[DATA_WIDTH:SHIFT]};
    assign w_im_rnd = {{(SHIFT-1){w_im_sum[DATA_WIDTH]}}, w_im_sum[DATA_WIDTH:SHIFT]};
    assign w_s2_re  = r_s1.scale ? w_re_rnd : r_s1.re;
    assign w_s2_im  = r_s1.scale ? w_im_rnd : r_s1.im;
    assign w_unused_lsb = ^{w_re_sum[SHIFT-1:0], w_im_sum[SHIFT-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mode  <= MODE_FWD;
            r_scale <= 1'b0;
        end else if (w_in_xfer) begin
            r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CNT_W'(1);
            if (w_first) begin
                r_mode  <= i_mode;
                r_scale <= i_scale_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_ready) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1.re    <= i_re;
                r_s1.im    <= w_s1_im;
                r_s1.last  <= (r_cnt == LAST_IDX);
                r_s1.sat   <= w_s1_sat;
                r_s1.first <= w_first;
                r_s1.scale <= w_scale;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_re    <= '0;
            r_s2_im    <= '0;
            r_s2_last  <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_first <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_re    <= w_s2_re;
                r_s2_im    <= w_s2_im;
                r_s2_last  <= r_s1.last;
                r_s2_sat   <= r_s1.sat;
                r_s2_first <= r_s1.first;
            end
        end
    end

    // First sample of a frame restarts the flag with its own tag, so a set still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_osat <= 1'b0;
        end else if (w_out_xfer) begin
            r_osat <= r_s2_first ? r_s2_sat : (r_osat | r_s2_sat);
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_s2_valid;
    assign o_re    = r_s2_re;
    assign o_im    = r_s2_im;
    assign o_last  = r_s2_last;
    assign o_sat   = r_osat;
endmodule

// File: tb/tb_ifft_conj_stage_16b.sv
// Scoreboard bench for ifft_conj_stage_16b: driver pushes expected samples, monitor pops and compares.
module tb_ifft_conj_stage_16b;
    logic        clk;
    logic        rst_n;
    logic        i_mode;
    logic        i_scale_en;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_re;
    logic [15:0] i_im;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_re;
    logic [15:0] o_im;
    logic        o_last;
    logic        o_sat;

    ifft_conj_stage_16b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mode     (i_mode),
        .i_scale_en (i_scale_en),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_re       (i_re),
        .i_im       (i_im),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_re       (o_re),
        .o_im       (o_im),
        .o_last     (o_last),
        .o_sat      (o_sat)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
        logic        sat;
        logic        first;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rnd   = 0;
    bit   chk_lat = 0;

    int   m_cnt   = 0;
    logic m_mode  = 0;
    logic m_scale = 0;
    logic m_osat  = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_neg(input logic [15:0] x);
        if (x == 16'h8000) return 16'h7FFF;
        return 16'(-x);
    endfunction

    function automatic logic [15:0] m_shr(input logic [15:0] x);
        int v;
        v = int'($signed(x)) + 32;
        v = v >>> 6;
        return 16'(v);
    endfunction

    // Issue one sample; retries until accepted. Hand values override the model data.
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic md,
                        input logic sc, input bit hand, input logic [15:0] hre,
                        input logic [15:0] him);
        int   budget = 0;
        bit   done = 0;
        exp_t e;
        logic [15:0] im1;
        while (!done) begin
            @(posedge clk); #1;
            i_re = re; i_im = im; i_mode = md; i_scale_en = sc;
            i_valid = rnd ? 1'($urandom % 2) : 1'b1;
            i_ready = rnd ? 1'($urandom % 2) : 1'b1;
            @(negedge clk);
            if (i_valid && o_ready) begin
                if (m_cnt == 0) begin m_mode = md; m_scale = sc; end
                im1     = m_mode ? m_neg(im) : im;
                e.sat   = m_mode && (im == 16'h8000);
                e.re    = m_scale ? m_shr(re)  : re;
                e.im    = m_scale ? m_shr(im1) : im1;
                if (hand) begin e.re = hre; e.im = him; end
                e.first = (m_cnt == 0);
                e.last  = (m_cnt == 63);
                e.cyc   = cyc;
                q.push_back(e);
                m_cnt = (m_cnt + 1) % 64;
                done  = 1;
            end else if (++budget > 300) begin
                chk("send_timeout", 32'(budget), 32'd300);
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int budget = 0;
        @(posedge clk); #1;
        i_valid = 0; i_ready = 1;
        while (q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    // Monitor: o_sat every cycle, hold-while-stalled, and scoreboard pops on transfer.
    initial begin
        exp_t        e;
        bit          stall_prev = 0;
        logic [15:0] h_re, h_im;
        logic        h_last;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_osat = 0; stall_prev = 0;
                continue;
            end
            chk("o_sat", 32'(o_sat), 32'(m_osat));
            if (stall_prev) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_re", 32'(o_re), 32'(h_re));
                chk("hold_im", 32'(o_im), 32'(h_im));
                chk("hold_last", 32'(o_last), 32'(h_last));
            end
            stall_prev = o_valid && !i_ready;
            h_re = o_re; h_im = o_im; h_last = o_last;
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output act=%h/%h exp=none", o_re, o_im);
                end else begin
                    e = q.pop_front();
                    chk("o_re", 32'(o_re), 32'(e.re));
                    chk("o_im", 32'(o_im), 32'(e.im));
                    chk("o_last", 32'(o_last), 32'(e.last));
                    if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    m_osat = e.first ? e.sat : (m_osat | e.sat);
                end
            end
        end
    end

    initial begin
        logic [15:0] v, w;
        rst_n = 0; i_mode = 0; i_scale_en = 0; i_valid = 0; i_ready = 0;
        i_re = 0; i_im = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_re", 32'(o_re), 32'd0);
        chk("rst_im", 32'(o_im), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_sat", 32'(o_sat), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1;

        // Conjugate, no scale: o_im=-k, two-cycle latency, o_last on sample 63.
        chk_lat = 1;
        for (int k = 0; k < 64; k++)
            send(16'(k), 16'(k), 1, 0, 1, 16'(k), 16'(-k));
        drain();

        // Saturating sample mid-frame, then a clean frame back-to-back.
        for (int k = 0; k < 64; k++) begin
            v = (k == 20) ? 16'h8000 : 16'(k * 3);
            w = (k == 20) ? 16'h7FFF : 16'(-(k * 3));
            send(16'(k), v, 1, 0, 1, 16'(k), w);
        end
        for (int k = 0; k < 64; k++)
            send(16'(k + 7), 16'(k), 0, 0, 1, 16'(k + 7), 16'(k));
        // Saturation on sample 0: clear and set together, set wins.
        for (int k = 0; k < 64; k++) begin
            v = (k == 0) ? 16'h8000 : 16'(100 + k);
            w = (k == 0) ? 16'h7FFF : 16'(-(100 + k));
            send(16'h1234, v, 1, 0, 1, 16'h1234, w);
        end
        drain();
        chk_lat = 0;

        // Scaling with rounding half up, arithmetic shift.
        send(16'd95,    16'd0, 0, 1, 1, 16'd1,     16'd0);
        send(16'd96,    16'd0, 0, 1, 1, 16'd2,     16'd0);
        send(16'hFF9F,  16'd0, 0, 1, 1, 16'hFFFE,  16'd0);
        send(16'h7FFF,  16'd0, 0, 1, 1, 16'h0200,  16'd0);
        for (int k = 4; k < 64; k++)
            send(16'($urandom), 16'($urandom), 0, 1, 0, 0, 0);
        drain();

        // Mode toggled at sample 10 is ignored until the next frame.
        for (int k = 0; k < 64; k++)
            send(16'(k), 16'(k * 7 + 1), (k < 10) ? 1'b1 : 1'b0, 0, 1, 16'(k), 16'(-(k * 7 + 1)));
        for (int k = 0; k < 64; k++)
            send(16'(k), 16'(k * 5), 0, 0, 1, 16'(k), 16'(k * 5));
        drain();

        // Random valid/ready over four frames against the model.
        rnd = 1;
        for (int k = 0; k < 256; k++) begin
            v = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
            send(16'($urandom), v, 1'($urandom % 2), 1'($urandom % 2), 0, 0, 0);
        end
        rnd = 0;
        drain();

        // Reset mid-frame with the pipeline full.
        for (int k = 0; k < 31; k++)
            send(16'(k), 16'(k), 1, 0, 1, 16'(k), 16'(-k));
        @(posedge clk); #1;
        i_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_last", 32'(o_last), 32'd0);
        chk("midrst_sat", 32'(o_sat), 32'd0);
        q.delete();
        m_cnt = 0; m_mode = 0; m_scale = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 64; k++)
            send(16'(k + 1000), 16'(k + 1), 1, 0, 1, 16'(k + 1000), 16'(-(k + 1)));
        drain();
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
